// File: rtl/tdt_dmi_clk_gate_ctrl.sv
// ============================================================================
// tdt_dmi_clk_gate_ctrl : enable sequencer for the DMI gated clock cell.
// Optional idle hold-off: TDT_DMI_CLK_IDLE_HOLD_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module tdt_dmi_clk_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic               dmi_clk,
  input  logic               dmi_rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  output logic [NUM_REQ-1:0] ack,
  output logic               local_en,
  output logic [1:0]         gate_state
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
`ifdef TDT_DMI_CLK_IDLE_HOLD_EN
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
`endif

  // Reject parameter sets the counter cannot represent.
  if (NUM_REQ < 1 || NUM_REQ > 16 || WAKE_CYCLES < 1 || HOLD_CYCLES < 1 ||
      (WAKE_CYCLES - 1) >= (2 ** CNT_W) || (HOLD_CYCLES - 1) >= (2 ** CNT_W)) begin : g_param_chk
    $error("tdt_dmi_clk_gate_ctrl: illegal parameter combination");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_req;

  assign any_req    = (|req) | force_on;
  assign gate_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (any_req) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      // The wake always runs to completion, regardless of request changes.
      S_WAKE: begin
        if (cnt_q == '0) state_d = S_ON;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ON: begin
        if (!any_req) begin
`ifdef TDT_DMI_CLK_IDLE_HOLD_EN
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
`else
          state_d = S_OFF;
`endif
        end
      end
`ifdef TDT_DMI_CLK_IDLE_HOLD_EN
      // A request arriving on the final hold cycle still wins over gating.
      S_HOLD: begin
        if (any_req)             state_d = S_ON;
        else if (cnt_q == '0)    state_d = S_OFF;
        else                     cnt_d   = cnt_q - CNT_W'(1);
      end
`endif
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge dmi_clk or posedge dmi_rst) begin
    if (dmi_rst) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      local_en <= 1'b0;
      ack      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      local_en <= (state_d != S_OFF);
      ack      <= req & {NUM_REQ{state_d == S_ON}};
    end
  end

endmodule

`default_nettype wire
